// File: rtl/adapter_pkg.sv
// ---------------------------------------------------------------------------
// adapter_pkg
// Shared definitions for the accelerator BRAM adapter blocks.
//   fill_state_t : encoding of the stream-to-BRAM fill FSM
//   BYTE_BITS    : bits per BRAM byte lane
//   we_width()   : number of byte write enables for a given data width, which
//                  is also the width of the all-ones write-enable pattern
// ---------------------------------------------------------------------------
package adapter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } fill_state_t;

    localparam int BYTE_BITS = 8;

    function automatic int we_width(input int data_width);
        return data_width / BYTE_BITS;
    endfunction

endpackage

// File: rtl/adapter_axis_to_bram.sv
// ---------------------------------------------------------------------------
// adapter_axis_to_bram
// Fills the accelerator input BRAM from an AXI4-Stream. After a start pulse,
// each accepted beat is written at the next address starting from 0. The fill
// ends on tlast or when C_DATA_DEPTH words have been written, and done is then
// held until the next start.
//
// Ports
//   ACC_CLK, ARESET      clock and synchronous active-high reset
//   start                pulse, arms a fill (ignored while a fill is running)
//   CTRL_EN_INPUT_IF     adapter input mux select; stream is stalled when 0
//   s_axis_*             AXI4-Stream slave (tdata/tvalid/tlast/tready)
//   input_addr/din/we/en registered BRAM write port
//   done                 fill complete level
//   word_count           words written in the current or last fill
//   err                  sticky frame error
//
// Build option
//   ADAPTER_AXIS2BRAM_ERR_EN : when defined, err flags a frame whose tlast does
//   not coincide with the last BRAM word. When undefined, err is constant 0.
// ---------------------------------------------------------------------------
module adapter_axis_to_bram
    import adapter_pkg::*;
#(
    parameter int C_DATA_DEPTH = 16,
    parameter int C_ADDR_WIDTH = 4,
    parameter int C_DATA_WIDTH = 32
) (
    input  logic                          ACC_CLK,
    input  logic                          ARESET,
    input  logic                          start,
    input  logic                          CTRL_EN_INPUT_IF,
    input  logic [C_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [C_ADDR_WIDTH-1:0]       input_addr,
    output logic [C_DATA_WIDTH-1:0]       input_din,
    output logic [C_DATA_WIDTH/8-1:0]     input_we,
    output logic                          input_en,
    output logic                          done,
    output logic [C_ADDR_WIDTH:0]         word_count,
    output logic                          err
);

    localparam int WE_W = we_width(C_DATA_WIDTH);

    // Count value held while the final word of a full BRAM is being accepted.
    localparam logic [C_ADDR_WIDTH:0] COUNT_LAST = (C_ADDR_WIDTH + 1)'(C_DATA_DEPTH - 1);

    fill_state_t               state_reg;
    logic [C_ADDR_WIDTH:0]     count_reg;
    logic [C_ADDR_WIDTH-1:0]   addr_reg;
    logic [C_DATA_WIDTH-1:0]   din_reg;
    logic [WE_W-1:0]           we_reg;
    logic                      en_reg;
    logic                      done_reg;

    logic beat_accept;
    logic fill_full;

    // tready depends only on registered state and the mux select, so the
    // FSM leaves FILL one cycle after the final beat and nothing past the
    // last address can be accepted.
    assign s_axis_tready = (state_reg == ST_FILL) && CTRL_EN_INPUT_IF;
    assign beat_accept   = s_axis_tvalid && s_axis_tready;
    assign fill_full     = (count_reg == COUNT_LAST);

`ifdef ADAPTER_AXIS2BRAM_ERR_EN
    logic err_reg;
`endif

    always_ff @(posedge ACC_CLK) begin
        if (ARESET) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            addr_reg  <= '0;
            din_reg   <= '0;
            we_reg    <= '0;
            en_reg    <= 1'b0;
            done_reg  <= 1'b0;
`ifdef ADAPTER_AXIS2BRAM_ERR_EN
            err_reg   <= 1'b0;
`endif
        end else begin
            // Write strobe lasts exactly one cycle per accepted beat.
            en_reg <= 1'b0;
            we_reg <= '0;

            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_reg <= ST_FILL;
                        count_reg <= '0;
                        done_reg  <= 1'b0;
`ifdef ADAPTER_AXIS2BRAM_ERR_EN
                        err_reg   <= 1'b0;
`endif
                    end
                end

                ST_FILL: begin
                    if (beat_accept) begin
                        en_reg    <= 1'b1;
                        we_reg    <= {WE_W{1'b1}};
                        addr_reg  <= count_reg[C_ADDR_WIDTH-1:0];
                        din_reg   <= s_axis_tdata;
                        count_reg <= count_reg + 1'b1;
                        if (s_axis_tlast || fill_full) begin
                            state_reg <= ST_DONE;
                            done_reg  <= 1'b1;
                        end
`ifdef ADAPTER_AXIS2BRAM_ERR_EN
                        // tlast without a full BRAM, or a full BRAM without
                        // tlast; both cases only occur on the final beat.
                        if (s_axis_tlast != fill_full) begin
                            err_reg <= 1'b1;
                        end
`endif
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign input_addr = addr_reg;
    assign input_din  = din_reg;
    assign input_we   = we_reg;
    assign input_en   = en_reg;
    assign done       = done_reg;
    assign word_count = count_reg;

`ifdef ADAPTER_AXIS2BRAM_ERR_EN
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

endmodule
